// File: rtl/tester_frontend_pkg.sv
// ============================================================================
// Module      : tester_frontend_pkg
// Description : Shared constants and types for the tester front-end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tester_frontend_pkg;

    localparam int c_out_div = 2;
    localparam int c_dut_div = 4;
    localparam int c_adc_div = 8;
    localparam int c_timeout = 1024;

    typedef logic [1:0]  byte_idx_t;
    typedef logic [31:0] cfg_word_t;

endpackage

`default_nettype wire

// File: rtl/clk_divider.sv
// ============================================================================
// Module      : clk_divider
// Description : Even-ratio clock divider producing a registered level, a
//               rise tick for the edge that raises it, and a rise counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_divider #(
    parameter int DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        clk_lvl,
    output logic        rise_tick,
    output logic [31:0] rise_count
);

    localparam int c_half  = DIV / 2;
    localparam int c_cnt_w = (c_half > 1) ? $clog2(c_half) : 1;

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_lvl;
    logic [31:0]        r_rise_cnt;
    logic               w_wrap;

    assign w_wrap    = (r_cnt == c_cnt_w'(c_half - 1));
    // Tick is valid during the cycle whose closing edge drives the level high.
    assign rise_tick = w_wrap & ~r_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_lvl      <= 1'b0;
            r_rise_cnt <= '0;
        end else begin
            if (w_wrap) begin
                r_cnt <= '0;
                r_lvl <= ~r_lvl;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            if (rise_tick) begin
                r_rise_cnt <= r_rise_cnt + 32'd1;
            end
        end
    end

    assign clk_lvl    = r_lvl;
    assign rise_count = r_rise_cnt;

endmodule

`default_nettype wire

// File: rtl/tester_frontend.sv
// ============================================================================
// Module      : tester_frontend
// Description : PC byte-stream to config-word parser, DUT clock generation
//               and ADC bus capture on the ADC clock's rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tester_frontend
    import tester_frontend_pkg::*;
#(
    parameter int OUT_DIV = c_out_div,
    parameter int DUT_DIV = c_dut_div,
    parameter int ADC_DIV = c_adc_div,
    parameter int TIMEOUT = c_timeout
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_cmd_valid,
    input  logic [7:0]  pc_cmd_data,
    output logic        pc_ack,
    output logic        config_en,
    output logic [31:0] config_data,
    input  logic [15:0] adc_in,
    output logic [15:0] adc_data,
    output logic        adc_ready,
    output logic        clk_out,
    output logic        dut_clk,
    output logic        adc_clk,
    output logic [31:0] dut_clk_counter,
    output logic [31:0] adc_clk_counter
);

    localparam int c_idle_w = $clog2(TIMEOUT + 1);

    byte_idx_t             r_idx;
    cfg_word_t             r_sr;
    cfg_word_t             r_cfg;
    logic                  r_cfg_en;
    logic                  r_ack;
    logic [c_idle_w-1:0]   r_idle;
    logic [15:0]           r_adc_data;
    logic                  r_adc_ready;

    logic                  w_adc_rise;
    logic                  w_unused_out_rise;
    logic [31:0]           w_unused_out_cnt;
    logic                  w_unused_dut_rise;

    clk_divider #(.DIV(OUT_DIV)) u_out_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_lvl    (clk_out),
        .rise_tick  (w_unused_out_rise),
        .rise_count (w_unused_out_cnt)
    );

    clk_divider #(.DIV(DUT_DIV)) u_dut_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_lvl    (dut_clk),
        .rise_tick  (w_unused_dut_rise),
        .rise_count (dut_clk_counter)
    );

    clk_divider #(.DIV(ADC_DIV)) u_adc_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_lvl    (adc_clk),
        .rise_tick  (w_adc_rise),
        .rise_count (adc_clk_counter)
    );

    // A valid byte always takes priority over the idle timeout clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_sr     <= '0;
            r_cfg    <= '0;
            r_cfg_en <= 1'b0;
            r_ack    <= 1'b0;
            r_idle   <= '0;
        end else begin
            r_ack    <= pc_cmd_valid;
            r_cfg_en <= 1'b0;
            if (pc_cmd_valid) begin
                r_idle <= '0;
                r_sr   <= {r_sr[23:0], pc_cmd_data};
                if (r_idx == 2'd3) begin
                    r_cfg    <= {r_sr[23:0], pc_cmd_data};
                    r_cfg_en <= 1'b1;
                    r_idx    <= '0;
                end else begin
                    r_idx <= r_idx + 2'd1;
                end
            end else if (r_idx != 2'd0) begin
                if (r_idle == c_idle_w'(TIMEOUT - 1)) begin
                    r_idx  <= '0;
                    r_sr   <= '0;
                    r_idle <= '0;
                end else begin
                    r_idle <= r_idle + c_idle_w'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adc_data  <= '0;
            r_adc_ready <= 1'b0;
        end else begin
            r_adc_ready <= w_adc_rise;
            if (w_adc_rise) begin
                r_adc_data <= adc_in;
            end
        end
    end

    assign pc_ack      = r_ack;
    assign config_en   = r_cfg_en;
    assign config_data = r_cfg;
    assign adc_data    = r_adc_data;
    assign adc_ready   = r_adc_ready;

endmodule

`default_nettype wire

// File: tb/tb_tester_frontend.sv
// ============================================================================
// Module      : tb_tester_frontend
// Description : Self-checking bench for tester_frontend with a behavioural
//               edge-number based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tester_frontend;

    localparam int c_out = 2;
    localparam int c_dut = 4;
    localparam int c_adc = 8;
    localparam int c_to  = 1024;

    logic        clk;
    logic        rst_n;
    logic        pc_cmd_valid;
    logic [7:0]  pc_cmd_data;
    logic        pc_ack;
    logic        config_en;
    logic [31:0] config_data;
    logic [15:0] adc_in;
    logic [15:0] adc_data;
    logic        adc_ready;
    logic        clk_out;
    logic        dut_clk;
    logic        adc_clk;
    logic [31:0] dut_clk_counter;
    logic [31:0] adc_clk_counter;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          n;
    logic [7:0]  q[$];
    int          m_idle;
    logic [31:0] m_cfg;
    logic        m_en;
    logic        m_ack;
    logic        m_rdy;
    logic [15:0] m_adc;
    logic [31:0] m_dcnt;
    logic [31:0] m_acnt;

    tester_frontend dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_cmd_valid    (pc_cmd_valid),
        .pc_cmd_data     (pc_cmd_data),
        .pc_ack          (pc_ack),
        .config_en       (config_en),
        .config_data     (config_data),
        .adc_in          (adc_in),
        .adc_data        (adc_data),
        .adc_ready       (adc_ready),
        .clk_out         (clk_out),
        .dut_clk         (dut_clk),
        .adc_clk         (adc_clk),
        .dut_clk_counter (dut_clk_counter),
        .adc_clk_counter (adc_clk_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic lvl(input int edge_n, input int div);
        return logic'((edge_n / (div / 2)) % 2);
    endfunction

    task automatic model_reset();
        n      = 0;
        q.delete();
        m_idle = 0;
        m_cfg  = '0;
        m_en   = 1'b0;
        m_ack  = 1'b0;
        m_rdy  = 1'b0;
        m_adc  = '0;
        m_dcnt = '0;
        m_acnt = '0;
    endtask

    task automatic chk_all();
        chk("pc_ack",      {31'd0, pc_ack},    {31'd0, m_ack});
        chk("config_en",   {31'd0, config_en}, {31'd0, m_en});
        chk("config_data", config_data,        m_cfg);
        chk("adc_ready",   {31'd0, adc_ready}, {31'd0, m_rdy});
        chk("adc_data",    {16'd0, adc_data},  {16'd0, m_adc});
        chk("clk_out",     {31'd0, clk_out},   {31'd0, lvl(n, c_out)});
        chk("dut_clk",     {31'd0, dut_clk},   {31'd0, lvl(n, c_dut)});
        chk("adc_clk",     {31'd0, adc_clk},   {31'd0, lvl(n, c_adc)});
        chk("dut_cnt",     dut_clk_counter,    m_dcnt);
        chk("adc_cnt",     adc_clk_counter,    m_acnt);
    endtask

    // Drive one cycle of inputs, advance one edge, update the model, check.
    task automatic tick(input logic v, input logic [7:0] d, input logic [15:0] a);
        pc_cmd_valid = v;
        pc_cmd_data  = d;
        adc_in       = a;
        @(posedge clk);
        n++;
        m_ack = v;
        m_en  = 1'b0;
        if (v) begin
            q.push_back(d);
            m_idle = 0;
            if (q.size() == 4) begin
                m_cfg = {q[0], q[1], q[2], q[3]};
                m_en  = 1'b1;
                q.delete();
            end
        end else if (q.size() != 0) begin
            m_idle++;
            if (m_idle == c_to) begin
                q.delete();
                m_idle = 0;
            end
        end
        m_rdy = 1'b0;
        if (n % c_adc == c_adc / 2) begin
            m_rdy  = 1'b1;
            m_adc  = a;
            m_acnt = m_acnt + 32'd1;
        end
        if (n % c_dut == c_dut / 2) m_dcnt = m_dcnt + 32'd1;
        #1;
        chk_all();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick(1'b0, 8'h00, 16'(($urandom)));
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) tick(1'b1, w[8*i +: 8], 16'h0000);
    endtask

    initial begin
        rst_n        = 1'b0;
        pc_cmd_valid = 1'b0;
        pc_cmd_data  = '0;
        adc_in       = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Word 0x12345678 with ADC capture: 0xBEEF, then 0x1234 from edge 8
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            logic [31:0] w;
            w = 32'h1234_5678;
            b = w[8*(3 - (i % 4)) +: 8];
            tick(i < 4, (i < 4) ? b : 8'h00, (n + 1 >= 8) ? 16'h1234 : 16'hBEEF);
            if (i == 3) chk("word1_en", {31'd0, config_en}, 32'd1);
            if (n == 4)  chk("adc_first",  {16'd0, adc_data}, 32'h0000_BEEF);
            if (n == 12) chk("adc_second", {16'd0, adc_data}, 32'h0000_1234);
        end
        chk("word1", config_data, 32'h1234_5678);

        // Divider counts observed just before edge 100
        while (n < 99) idle(1);
        chk("dut_cnt_100", dut_clk_counter, 32'd25);
        chk("adc_cnt_100", adc_clk_counter, 32'd12);

        // Partial word discarded after exactly TIMEOUT idle cycles
        tick(1'b1, 8'hAA, 16'h0);
        tick(1'b1, 8'hBB, 16'h0);
        idle(c_to);
        send_word(32'h0102_0304);
        chk("timeout_word", config_data, 32'h0102_0304);

        // One cycle short of the timeout: the word continues
        tick(1'b1, 8'h11, 16'h0);
        tick(1'b1, 8'h22, 16'h0);
        idle(c_to - 1);
        tick(1'b1, 8'h33, 16'h0);
        tick(1'b1, 8'h44, 16'h0);
        chk("no_timeout_word", config_data, 32'h1122_3344);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            tick(($urandom % 3) != 0, 8'($urandom), 16'($urandom));
        end

        // Edge counter wrap
        while (n % c_dut != c_dut / 2) idle(1);
        force dut.u_dut_div.r_rise_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.u_dut_div.r_rise_cnt;
        m_dcnt = 32'hFFFF_FFFF;
        chk("wrap_preset", dut_clk_counter, 32'hFFFF_FFFF);
        idle(c_dut);
        chk("wrap_zero", dut_clk_counter, 32'h0);

        // Asynchronous reset mid-word and mid-period
        while (n % c_adc != 3) idle(1);
        tick(1'b1, 8'hDE, 16'h0);
        tick(1'b1, 8'hAD, 16'h0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_word(32'hCAFE_F00D);
        chk("post_reset_word", config_data, 32'hCAFE_F00D);
        chk("post_reset_adc_clk", {31'd0, adc_clk}, 32'd1);
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
